// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for riscv-tests programs: watches PC, register writeback
// and tohost stores, latches a sticky verdict, failing test number and run length.
module riscv_test_monitor #(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  END_PC      = XLEN'(32'h44),
  parameter int unsigned      RES_REG     = 3,
  parameter logic [XLEN-1:0]  TOHOST_ADDR = XLEN'(32'h1000),
  parameter int unsigned      MODE        = 0,
  parameter int unsigned      TIMEOUT     = 5000,
  parameter int unsigned      CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-2:0]  test_num,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

  localparam bit               USE_PC   = (MODE == 0) || (MODE == 2);
  localparam bit               USE_TH   = (MODE == 1) || (MODE == 2);
  localparam bit               HAS_TMO  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [XLEN-1:0]  shadow_q, shadow_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [XLEN-2:0]  test_num_q, test_num_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic             res_wr;
  logic [XLEN-1:0]  res_eff;
  logic             pc_hit;
  logic             th_hit;
  logic [XLEN-1:0]  result;

  // Event detection and next-state / output computation.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    test_num_d = test_num_q;
    cycles_d   = cycles_q;

    res_wr  = wb_we && (wb_addr == 5'(RES_REG)) && (RES_REG != 0);
    res_eff = res_wr ? wb_data : shadow_q;
    pc_hit  = USE_PC && (pc == END_PC);
    th_hit  = USE_TH && mem_we && (mem_addr == TOHOST_ADDR);
    result  = th_hit ? mem_wdata : res_eff;

    if (res_wr) begin
      shadow_d = wb_data;
    end

    if (state_q == S_RUN) begin
      if (cycles_q != {CNT_W{1'b1}}) begin
        cycles_d = cycles_q + CNT_W'(1);
      end
      // A real event always beats a timeout landing in the same cycle.
      if (pc_hit || th_hit) begin
        done_d = 1'b1;
        if (result == XLEN'(1)) begin
          state_d    = S_PASS;
          pass_d     = 1'b1;
          test_num_d = '0;
        end else begin
          state_d    = S_FAIL;
          fail_d     = 1'b1;
          test_num_d = result[XLEN-1:1];
        end
      end else if (HAS_TMO && (cycles_q == TMO_LAST)) begin
        state_d    = S_TMO;
        done_d     = 1'b1;
        timeout_d  = 1'b1;
        test_num_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      shadow_q   <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      test_num_q <= '0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      test_num_q <= test_num_d;
      cycles_q   <= cycles_d;
    end
  end

  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign timeout  = timeout_q;
  assign test_num = test_num_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: three instances (MODE 0/2/1) share one stimulus
// stream and are compared every cycle against a verdict-level reference model.
module tb_riscv_test_monitor;

  localparam int V_NONE = 0;
  localparam int V_PASS = 1;
  localparam int V_FAIL = 2;
  localparam int V_TMO  = 3;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  logic [2:0]  done_w, pass_w, fail_w, tmo_w;
  logic [30:0] tn_w  [3];
  logic [31:0] cyc_w [3];

  int md [3] = '{0, 2, 1};
  int to [3] = '{20, 20, 0};

  int          m_v   [3];
  logic [31:0] m_cyc [3];
  logic [31:0] m_sh  [3];
  logic [30:0] m_tn  [3];

  int checks = 0;
  int errors = 0;

  riscv_test_monitor #(.XLEN(32), .MODE(0), .TIMEOUT(20)) dut0 (
    .clk(clk), .rst(rst), .pc(pc), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .timeout(tmo_w[0]),
    .test_num(tn_w[0]), .cycles(cyc_w[0]));

  riscv_test_monitor #(.XLEN(32), .MODE(2), .TIMEOUT(20)) dut1 (
    .clk(clk), .rst(rst), .pc(pc), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .timeout(tmo_w[1]),
    .test_num(tn_w[1]), .cycles(cyc_w[1]));

  riscv_test_monitor #(.XLEN(32), .MODE(1), .TIMEOUT(0)) dut2 (
    .clk(clk), .rst(rst), .pc(pc), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done_w[2]), .pass(pass_w[2]), .fail(fail_w[2]), .timeout(tmo_w[2]),
    .test_num(tn_w[2]), .cycles(cyc_w[2]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_v[i]   = V_NONE;
      m_cyc[i] = 0;
      m_sh[i]  = 0;
      m_tn[i]  = 0;
    end
  endtask

  // Verdict-level model: one call per rising edge, using the inputs held across it.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] r;
      bit ev, wq, th, ph;
      r = 0; ev = 0;
      if (rst) begin
        m_v[i] = V_NONE; m_cyc[i] = 0; m_sh[i] = 0; m_tn[i] = 0;
      end else begin
        wq = wb_we && (wb_addr == 5'd3);
        if (m_v[i] == V_NONE) begin
          th = (md[i] != 0) && mem_we && (mem_addr == 32'h1000);
          ph = (md[i] != 1) && (pc == 32'h44);
          if (th) begin ev = 1; r = mem_wdata; end
          else if (ph) begin ev = 1; r = wq ? wb_data : m_sh[i]; end
          if (ev) begin
            m_v[i]  = (r == 1) ? V_PASS : V_FAIL;
            m_tn[i] = (r == 1) ? 31'd0 : r[31:1];
          end else if (to[i] != 0 && m_cyc[i] == 32'(to[i] - 1)) begin
            m_v[i] = V_TMO;
          end
          if (m_cyc[i] != 32'hFFFF_FFFF) m_cyc[i] = m_cyc[i] + 1;
        end
        if (wq) m_sh[i] = wb_data;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d.done", i),     64'(done_w[i]), 64'(m_v[i] != V_NONE));
      chk($sformatf("d%0d.pass", i),     64'(pass_w[i]), 64'(m_v[i] == V_PASS));
      chk($sformatf("d%0d.fail", i),     64'(fail_w[i]), 64'(m_v[i] == V_FAIL));
      chk($sformatf("d%0d.timeout", i),  64'(tmo_w[i]),  64'(m_v[i] == V_TMO));
      chk($sformatf("d%0d.test_num", i), 64'(tn_w[i]),   64'(m_tn[i]));
      chk($sformatf("d%0d.cycles", i),   64'(cyc_w[i]),  64'(m_cyc[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [31:0] p, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic mwe, input logic [31:0] ma,
                       input logic [31:0] mwd);
    pc = p; wb_we = we; wb_addr = wa; wb_data = wd;
    mem_we = mwe; mem_addr = ma; mem_wdata = mwd;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  // Reset with X on every input, then release just after an edge.
  task automatic do_reset();
    rst = 1'b1;
    pc = 'x; wb_we = 'x; wb_addr = 'x; wb_data = 'x;
    mem_we = 'x; mem_addr = 'x; mem_wdata = 'x;
    #1;
    model_clear();
    check_all();
    tick();
    tick();
    rst = 1'b0;
    idle();
  endtask

  initial begin
    clk = 1'b0;
    model_clear();

    // 1: pass via END_PC with gp=1, counter frozen afterwards
    do_reset();
    drive(32'h10, 1'b1, 5'd3, 32'd1, 1'b0, 32'h0, 32'h0); tick();
    drive(32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0); tick();
    chk("t1.pass", 64'(pass_w[0]), 64'd1);
    idle(); tick(); tick(); tick();
    chk("t1.cycles_frozen", 64'(cyc_w[0]), 64'd2);

    // 2: fail with test 5, later activity ignored
    do_reset();
    drive(32'h10, 1'b1, 5'd3, 32'h0B, 1'b0, 32'h0, 32'h0); tick();
    drive(32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0); tick();
    chk("t2.test_num", 64'(tn_w[0]), 64'd5);
    drive(32'h44, 1'b1, 5'd3, 32'd1, 1'b0, 32'h0, 32'h0); tick(); tick();
    chk("t2.fail_sticky", 64'(fail_w[0]), 64'd1);
    chk("t2.no_pass", 64'(pass_w[0]), 64'd0);

    // 3: same-cycle writeback bypass over stale shadow value 7
    do_reset();
    drive(32'h10, 1'b1, 5'd3, 32'd7, 1'b0, 32'h0, 32'h0); tick();
    drive(32'h44, 1'b1, 5'd3, 32'd1, 1'b0, 32'h0, 32'h0); tick();
    chk("t3.bypass_pass", 64'(pass_w[0]), 64'd1);

    // 4: tohost store wins over END_PC in MODE 2
    do_reset();
    drive(32'h10, 1'b1, 5'd3, 32'd1, 1'b0, 32'h0, 32'h0); tick();
    drive(32'h44, 1'b0, 5'd0, 32'h0, 1'b1, 32'h1000, 32'h7); tick();
    chk("t4.m2_fail", 64'(fail_w[1]), 64'd1);
    chk("t4.m2_test_num", 64'(tn_w[1]), 64'd3);
    chk("t4.m0_pass", 64'(pass_w[0]), 64'd1);

    // 5: timeout on the 20th RUN cycle, and event beating timeout
    do_reset();
    for (int k = 0; k < 19; k++) tick();
    chk("t5.no_tmo_yet", 64'(tmo_w[0]), 64'd0);
    tick();
    chk("t5.timeout", 64'(tmo_w[0]), 64'd1);
    chk("t5.cycles", 64'(cyc_w[0]), 64'd20);
    do_reset();
    drive(32'h10, 1'b1, 5'd3, 32'd1, 1'b0, 32'h0, 32'h0); tick();
    idle();
    for (int k = 0; k < 18; k++) tick();
    drive(32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0); tick();
    chk("t5.event_wins", 64'(pass_w[0]), 64'd1);
    chk("t5.no_tmo", 64'(tmo_w[0]), 64'd0);

    // 6: asynchronous reset mid-run and after a verdict
    do_reset();
    for (int k = 0; k < 10; k++) tick();
    #2 rst = 1'b1;
    #1 model_clear();
    check_all();
    chk("t6.async_cycles", 64'(cyc_w[0]), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6.restart", 64'(cyc_w[0]), 64'd1);
    drive(32'h10, 1'b1, 5'd3, 32'd1, 1'b0, 32'h0, 32'h0); tick();
    drive(32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0); tick();
    #2 rst = 1'b1;
    #1 model_clear();
    check_all();
    chk("t6.async_pass", 64'(pass_w[0]), 64'd0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // Randomized runs with occasional END_PC, gp writes and tohost stores
    for (int it = 0; it < 12; it++) begin
      do_reset();
      for (int k = 0; k < 30; k++) begin
        pc        = ($urandom_range(0, 9) == 0) ? 32'h44 : {$urandom_range(0, 255), 2'b00};
        wb_we     = 1'($urandom_range(0, 1));
        wb_addr   = ($urandom_range(0, 2) == 0) ? 5'd3 : 5'($urandom);
        wb_data   = ($urandom_range(0, 2) == 0) ? 32'd1 : 32'($urandom_range(0, 40));
        mem_we    = 1'($urandom_range(0, 1));
        mem_addr  = ($urandom_range(0, 7) == 0) ? 32'h1000 : {$urandom_range(0, 2047), 2'b00};
        mem_wdata = ($urandom_range(0, 2) == 0) ? 32'd1 : $urandom;
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
